// File: rtl/apb_slave_regfile.sv
// APB completer serving a small 32-bit register file (word 0 = read-only ID),
// with a fixed number of wait states and an error response for bad accesses.
module apb_slave_regfile #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter int          SEL_BIT     = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [15:0] xfer_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [4:0] NREGS     = 5'(NUM_REGS);
  localparam logic [3:0] WCNT_INIT = 4'(WAIT_STATES);

  state_t      state, state_next;
  logic [3:0]  wcnt, wcnt_next;
  logic [3:0]  idx_lat;
  logic        write_lat, err_lat;
  logic [31:0] wdata_lat;
  logic [31:0] regs [1:NUM_REGS-1];

  logic        sel, latch, commit;
  logic [3:0]  eff_idx;
  logic        eff_write, eff_err;
  logic [31:0] rd_word;
  logic        unused_bits;

  function automatic logic addr_err(input logic [5:0] a, input logic wr);
    return (a[1:0] != 2'b00) || ({1'b0, a[5:2]} >= NREGS) || (wr && (a[5:2] == 4'd0));
  endfunction

  assign sel         = Pselx[SEL_BIT];
  assign unused_bits = ^{Pselx, Paddr[31:6]};

  // Zero-wait entry into ACCESS happens on the setup edge itself, so the
  // read data and error must come from the live bus rather than the latches.
  assign eff_idx   = latch ? Paddr[5:2] : idx_lat;
  assign eff_write = latch ? Pwrite     : write_lat;
  assign eff_err   = latch ? addr_err(Paddr[5:0], Pwrite) : err_lat;

  always_comb begin
    rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++)
      if (eff_idx == 4'(i)) rd_word = regs[i];
  end

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    latch      = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel && !Penable) begin
          latch = 1'b1;
          if (WAIT_STATES > 0) begin
            state_next = S_WAIT;
            wcnt_next  = WCNT_INIT;
          end else begin
            state_next = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (!sel)             state_next = S_IDLE;
        else if (wcnt == 4'd1) state_next = S_ACCESS;
        else                  wcnt_next  = wcnt - 4'd1;
      end
      S_ACCESS: begin
        if (!sel) begin
          state_next = S_IDLE;
        end else if (Penable) begin
          commit     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      idx_lat   <= '0;
      write_lat <= 1'b0;
      err_lat   <= 1'b0;
      wdata_lat <= '0;
      Pready    <= 1'b0;
      Pslverr   <= 1'b0;
      Prdata    <= '0;
      xfer_cnt  <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      if (latch) begin
        idx_lat   <= Paddr[5:2];
        write_lat <= Pwrite;
        wdata_lat <= Pwdata;
        err_lat   <= addr_err(Paddr[5:0], Pwrite);
      end
      Pready  <= (state_next == S_ACCESS);
      Pslverr <= (state_next == S_ACCESS) && eff_err;
      if (state_next != S_ACCESS)
        Prdata <= '0;
      else if (state != S_ACCESS)
        Prdata <= (eff_write || eff_err) ? '0 : rd_word;
      if (commit) begin
        xfer_cnt <= xfer_cnt + 16'd1;
        if (write_lat && !err_lat)
          for (int i = 1; i < NUM_REGS; i++)
            if (idx_lat == 4'(i)) regs[i] <= wdata_lat;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two completers on one bus (zero-wait on Pselx[0],
// three-wait on Pselx[1]) driven by directed and random transfers vs. a word-array model.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  Pselx;
  logic        Penable, Pwrite;
  logic [31:0] Paddr, Pwdata;
  logic [31:0] rdata  [2];
  logic        ready  [2];
  logic        slverr [2];
  logic [15:0] cnt    [2];

  always #5 clk = ~clk;

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(0), .SEL_BIT(0), .ID_VALUE(ID)) dut0 (
    .clk(clk), .rst(rst), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rdata[0]), .Pready(ready[0]),
    .Pslverr(slverr[0]), .xfer_cnt(cnt[0]));

  apb_slave_regfile #(.NUM_REGS(8), .WAIT_STATES(3), .SEL_BIT(1), .ID_VALUE(ID)) dut1 (
    .clk(clk), .rst(rst), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rdata[1]), .Pready(ready[1]),
    .Pslverr(slverr[1]), .xfer_cnt(cnt[1]));

  int          ws [2] = '{0, 3};
  logic [31:0] mem  [2][16];
  logic [15:0] mcnt [2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mcnt[s] = 16'd0;
      for (int i = 0; i < 16; i++) mem[s][i] = 32'd0;
    end
  endtask

  function automatic logic exp_err(input logic wr, input logic [31:0] a);
    int idx;
    idx = int'(a[5:2]);
    return (a[1:0] != 2'b00) || (idx >= 8) || (wr && idx == 0);
  endfunction

  task automatic idle_bus();
    Pselx   = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = $urandom;
    Pwdata  = $urandom;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the completing edge.
  task automatic xfer(input int s, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input bit b2b);
    logic        e;
    logic [31:0] er;
    int          idx, waits;
    idx = int'(a[5:2]);
    e   = exp_err(wr, a);
    er  = (wr || e) ? 32'd0 : ((idx == 0) ? ID : mem[s][idx]);
    Pselx   = 3'(1 << s);
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = a;
    Pwdata  = d;
    @(negedge clk);
    chk("idle_ready", 32'(ready[s]), 32'd0);
    chk("idle_rdata", rdata[s], 32'd0);
    chk("xfer_cnt", 32'(cnt[s]), 32'(mcnt[s]));
    @(posedge clk);
    #1;
    Penable = 1'b1;
    Paddr   = $urandom;
    Pwdata  = $urandom;
    waits = 0;
    @(negedge clk);
    while (!ready[s] && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    chk("wait_cycles", 32'(waits), 32'(ws[s]));
    chk("slverr", 32'(slverr[s]), 32'(e));
    chk("rdata", rdata[s], er);
    chk("other_ready", 32'(ready[1-s]), 32'd0);
    @(posedge clk);
    if (wr && !e) mem[s][idx] = d;
    mcnt[s] = mcnt[s] + 16'd1;
    #1;
    if (!b2b) idle_bus();
  endtask

  initial begin
    logic [31:0] a;
    int          s, idx;
    bit          wr, b2b;

    idle_bus();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", 32'(ready[k]), 32'd0);
      chk("rst_slverr", 32'(slverr[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_cnt", 32'(cnt[k]), 32'd0);
    end
    sync();

    // zero-wait write then read
    xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0);
    sync();
    xfer(0, 1'b0, 32'h04, 32'h0, 1'b0);
    @(negedge clk);
    chk("zw_cnt", 32'(cnt[0]), 32'd2);
    sync();

    // three-wait ID read
    xfer(1, 1'b0, 32'h00, 32'h0, 1'b0);
    sync();

    // error responses
    xfer(0, 1'b1, 32'h00, 32'h1234_5678, 1'b0);
    xfer(0, 1'b0, 32'h20, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h06, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h00, 32'h0, 1'b0);
    @(negedge clk);
    chk("err_cnt", 32'(cnt[0]), 32'd6);
    sync();

    // back-to-back writes
    xfer(0, 1'b1, 32'h08, 32'd1, 1'b1);
    xfer(0, 1'b1, 32'h0C, 32'd2, 1'b1);
    xfer(0, 1'b0, 32'h08, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h0C, 32'h0, 1'b0);
    sync();

    // abort during wait states
    Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h10; Pwdata = 32'd55;
    sync();
    Penable = 1'b1;
    @(negedge clk);
    chk("abort_ready0", 32'(ready[1]), 32'd0);
    sync();
    idle_bus();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_ready", 32'(ready[1]), 32'd0);
    end
    sync();
    xfer(1, 1'b0, 32'h10, 32'h0, 1'b0);
    sync();

    // stray enable without setup, and a transfer to a foreign select bit
    Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b1; Paddr = 32'h04; Pwdata = 32'h0;
    sync();
    Pselx = 3'b100; Penable = 1'b0;
    @(negedge clk);
    chk("stray_ready", 32'(ready[0]), 32'd0);
    sync();
    Penable = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("foreign_ready0", 32'(ready[0]), 32'd0);
      chk("foreign_ready1", 32'(ready[1]), 32'd0);
    end
    sync();
    idle_bus();
    sync();
    xfer(0, 1'b0, 32'h04, 32'h0, 1'b0);
    sync();

    // reset while in ACCESS
    Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h14; Pwdata = 32'd7;
    sync();
    Penable = 1'b1;
    @(negedge clk);
    chk("pre_rst_ready", 32'(ready[0]), 32'd1);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    idle_bus();
    model_reset();
    @(negedge clk);
    chk("mid_rst_ready", 32'(ready[0]), 32'd0);
    chk("mid_rst_slverr", 32'(slverr[0]), 32'd0);
    chk("mid_rst_rdata", rdata[0], 32'd0);
    chk("mid_rst_cnt0", 32'(cnt[0]), 32'd0);
    chk("mid_rst_cnt1", 32'(cnt[1]), 32'd0);
    sync();
    xfer(0, 1'b0, 32'h14, 32'h0, 1'b0);
    sync();

    // random traffic
    for (int n = 0; n < 80; n++) begin
      s   = $urandom_range(0, 1);
      wr  = 1'($urandom_range(0, 1));
      idx = $urandom_range(0, 9);
      a   = $urandom;
      a[5:2] = 4'(idx);
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b2b = 1'($urandom_range(0, 1));
      xfer(s, wr, a, $urandom, b2b);
      if (!b2b) repeat ($urandom_range(1, 2)) sync();
    end
    idle_bus();
    @(negedge clk);
    chk("final_cnt0", 32'(cnt[0]), 32'(mcnt[0]));
    chk("final_cnt1", 32'(cnt[1]), 32'(mcnt[1]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
